// File: rtl/board_tile_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : board_tile_renderer
// Purpose  : Renders a packed 4x4 game board (16 tiles x 12 bits) as VGA
//            video. Generates its own sync timing from Clk, snapshots the
//            board once per frame so a frame never tears, decodes each tile
//            to a log2 code and draws a coloured tile with a value bar whose
//            length is 8 px per code step.
// Ports    : Clk         in   board clock, rising edge
//            Reset       in   active-low synchronous reset
//            MatrixCopy  in   192-bit board, tile i = [12i+11:12i], i=4*row+col
//            Test        in   test-pattern select (tile i shows (i mod 11)+1)
//            vga_h_sync  out  active-low horizontal sync
//            vga_v_sync  out  active-low vertical sync
//            vga_r/g/b   out  pixel colour, one bit each
//            frame_start out  one-Clk pulse when the board snapshot is taken
// Revision : 1.0 - initial release
// ============================================================================
module board_tile_renderer #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int HS_START = 656,
  parameter int HS_END   = 752,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int VS_START = 490,
  parameter int VS_END   = 492,
  parameter int BOARD_X0 = 120,
  parameter int BOARD_Y0 = 40,
  parameter int TILE     = 100,
  parameter int GAP      = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [191:0] MatrixCopy,
  input  logic         Test,
  output logic         vga_h_sync,
  output logic         vga_v_sync,
  output logic         vga_r,
  output logic         vga_g,
  output logic         vga_b,
  output logic         frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int OFF_W = $clog2(TILE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_S    = 10'(HS_START);
  localparam logic [9:0] HS_E    = 10'(HS_END);
  localparam logic [9:0] VS_S    = 10'(VS_START);
  localparam logic [9:0] VS_E    = 10'(VS_END);
  localparam logic [9:0] BX0     = 10'(BOARD_X0);
  localparam logic [9:0] BY0     = 10'(BOARD_Y0);
  localparam logic [9:0] BX1     = 10'(BOARD_X0 + 4 * TILE);
  localparam logic [9:0] BY1     = 10'(BOARD_Y0 + 4 * TILE);
  localparam logic [9:0] T1      = 10'(TILE);
  localparam logic [9:0] T2      = 10'(2 * TILE);
  localparam logic [9:0] T3      = 10'(3 * TILE);
  localparam logic [9:0] GAP_10  = 10'(GAP);
  localparam logic [OFF_W-1:0] GAP_LO = OFF_W'(GAP);
  localparam logic [OFF_W-1:0] GAP_HI = OFF_W'(TILE - GAP);
  localparam logic [OFF_W-1:0] BAR_Y0 = OFF_W'(TILE - GAP - 8);

  // Timing state
  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hcount, vcount;
  logic [191:0]     shadow;
  logic             pix_en, h_last, v_last;

  // Stage 1: position decode
  logic             s1_active, s1_in_board, s1_hs, s1_vs;
  logic [3:0]       s1_idx;
  logic [OFF_W-1:0] s1_ox, s1_oy;

  // Stage 2: tile code
  logic             s2_active, s2_in_board, s2_hs, s2_vs;
  logic [3:0]       s2_code;
  logic [OFF_W-1:0] s2_ox, s2_oy;

  // Combinational helpers
  logic [9:0]       x_rel, y_rel;
  logic [1:0]       col, row;
  logic [OFF_W-1:0] x_off, y_off;
  logic [11:0]      tile_arr [16];
  logic [11:0]      tile_val;
  logic [3:0]       enc_code, test_code;
  logic [9:0]       bar_end;
  logic             gap, bar;
  logic [2:0]       rgb_next;

  assign pix_en = (div_cnt == DIV_LAST);
  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  // Column/row and in-tile offset via range compares against tile edges.
  assign x_rel = hcount - BX0;
  assign y_rel = vcount - BY0;

  always_comb begin
    col   = 2'd3;
    x_off = OFF_W'(x_rel - T3);
    if (x_rel < T1) begin
      col   = 2'd0;
      x_off = OFF_W'(x_rel);
    end else if (x_rel < T2) begin
      col   = 2'd1;
      x_off = OFF_W'(x_rel - T1);
    end else if (x_rel < T3) begin
      col   = 2'd2;
      x_off = OFF_W'(x_rel - T2);
    end
  end

  always_comb begin
    row   = 2'd3;
    y_off = OFF_W'(y_rel - T3);
    if (y_rel < T1) begin
      row   = 2'd0;
      y_off = OFF_W'(y_rel);
    end else if (y_rel < T2) begin
      row   = 2'd1;
      y_off = OFF_W'(y_rel - T1);
    end else if (y_rel < T3) begin
      row   = 2'd2;
      y_off = OFF_W'(y_rel - T2);
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_tile_view
    assign tile_arr[gi] = shadow[12*gi +: 12];
  end

  assign tile_val = tile_arr[s1_idx];

  // Only exact powers 2..2048 get a code; 0 is empty; anything else is 15.
  always_comb begin
    enc_code = 4'd15;
    if (tile_val == 12'd0) begin
      enc_code = 4'd0;
    end else begin
      for (int k = 1; k <= 11; k++) begin
        if (tile_val == (12'd1 << k)) enc_code = 4'(k);
      end
    end
  end

  // (i mod 11) + 1 for i in 0..15
  assign test_code = (s1_idx < 4'd11) ? (s1_idx + 4'd1) : (s1_idx - 4'd10);

  assign bar_end = GAP_10 + {3'b000, s2_code, 3'b000};
  assign gap = (s2_ox < GAP_LO) || (s2_ox >= GAP_HI) ||
               (s2_oy < GAP_LO) || (s2_oy >= GAP_HI);
  assign bar = (s2_oy >= BAR_Y0) && (s2_oy < GAP_HI) &&
               (s2_ox >= GAP_LO) && (10'(s2_ox) < bar_end);

  always_comb begin
    rgb_next = 3'b000;
    if (!s2_active || !s2_in_board) begin
      rgb_next = 3'b000;
    end else if (gap) begin
      rgb_next = 3'b111;
    end else if (s2_code == 4'd15) begin
      rgb_next = 3'b100;
    end else if (s2_code == 4'd0) begin
      rgb_next = 3'b001;
    end else if (bar) begin
      rgb_next = 3'b111;
    end else begin
      case (s2_code)
        4'd1, 4'd6, 4'd11: rgb_next = 3'b110;
        4'd2, 4'd7:        rgb_next = 3'b100;
        4'd3, 4'd8:        rgb_next = 3'b010;
        4'd4, 4'd9:        rgb_next = 3'b011;
        4'd5, 4'd10:       rgb_next = 3'b101;
        default:           rgb_next = 3'b000;
      endcase
    end
  end

  // Sync stages carry "sync asserted" active-high so a zeroed pipeline
  // drives idle-high sync outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      shadow      <= '0;
      s1_active   <= 1'b0;
      s1_in_board <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_idx      <= '0;
      s1_ox       <= '0;
      s1_oy       <= '0;
      s2_active   <= 1'b0;
      s2_in_board <= 1'b0;
      s2_hs       <= 1'b0;
      s2_vs       <= 1'b0;
      s2_code     <= '0;
      s2_ox       <= '0;
      s2_oy       <= '0;
      vga_h_sync  <= 1'b1;
      vga_v_sync  <= 1'b1;
      vga_r       <= 1'b0;
      vga_g       <= 1'b0;
      vga_b       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= pix_en ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
        if (h_last && v_last) begin
          shadow      <= MatrixCopy;
          frame_start <= 1'b1;
        end

        s1_active   <= (hcount < H_ACT) && (vcount < V_ACT);
        s1_in_board <= (hcount >= BX0) && (hcount < BX1) &&
                       (vcount >= BY0) && (vcount < BY1);
        s1_hs       <= (hcount >= HS_S) && (hcount < HS_E);
        s1_vs       <= (vcount >= VS_S) && (vcount < VS_E);
        s1_idx      <= {row, col};
        s1_ox       <= x_off;
        s1_oy       <= y_off;

        s2_active   <= s1_active;
        s2_in_board <= s1_in_board;
        s2_hs       <= s1_hs;
        s2_vs       <= s1_vs;
        s2_code     <= Test ? test_code : enc_code;
        s2_ox       <= s1_ox;
        s2_oy       <= s1_oy;

        vga_h_sync  <= ~s2_hs;
        vga_v_sync  <= ~s2_vs;
        {vga_r, vga_g, vga_b} <= rgb_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_tile_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_board_tile_renderer
// Purpose  : Self-checking bench for board_tile_renderer on a reduced video
//            geometry. Every pixel of three frames is compared against a
//            reference built from the tile/colour rules, with random boards,
//            a mid-frame board change and a mid-frame Test switch.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_tile_renderer;

  localparam int PIX_DIV  = 2;
  localparam int H_ACTIVE = 96;
  localparam int H_TOTAL  = 112;
  localparam int HS_START = 100;
  localparam int HS_END   = 108;
  localparam int V_ACTIVE = 88;
  localparam int V_TOTAL  = 92;
  localparam int VS_START = 89;
  localparam int VS_END   = 91;
  localparam int BOARD_X0 = 8;
  localparam int BOARD_Y0 = 4;
  localparam int TILE     = 20;
  localparam int GAP      = 2;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [191:0] mc;
  logic         test;
  logic         h_sync, v_sync, r, g, b, fs;

  board_tile_renderer #(
    .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .HS_START(HS_START), .HS_END(HS_END), .V_ACTIVE(V_ACTIVE),
    .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_END(VS_END),
    .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0), .TILE(TILE), .GAP(GAP)
  ) dut (
    .Clk(clk), .Reset(rst_n), .MatrixCopy(mc), .Test(test),
    .vga_h_sync(h_sync), .vga_v_sync(v_sync),
    .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e_cnt;
  int first_fs;
  int hs_low, vs_low;
  logic [191:0] shadow_m;
  logic [2:0]   pend, held_rgb;
  logic         held_hs, held_vs, held_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int enc(input logic [11:0] v);
    if (v == 12'd0) return 0;
    for (int k = 1; k <= 11; k++) if (v == 12'(1 << k)) return k;
    return 15;
  endfunction

  // Colour of linear pixel index p given the board and Test in force.
  function automatic logic [2:0] colour(input int p, input logic [191:0] bd, input logic t);
    int x, y, bx, by, col, row, ox, oy, code, i;
    if (p < 0) return 3'b000;
    x = p % H_TOTAL;
    y = (p / H_TOTAL) % V_TOTAL;
    if (x >= H_ACTIVE || y >= V_ACTIVE) return 3'b000;
    bx = x - BOARD_X0;
    by = y - BOARD_Y0;
    if (bx < 0 || bx >= 4 * TILE || by < 0 || by >= 4 * TILE) return 3'b000;
    col = bx / TILE; ox = bx % TILE;
    row = by / TILE; oy = by % TILE;
    if (ox < GAP || ox >= TILE - GAP || oy < GAP || oy >= TILE - GAP) return 3'b111;
    i = row * 4 + col;
    code = t ? (i % 11) + 1 : enc(bd[12*i +: 12]);
    if (code == 15) return 3'b100;
    if (code == 0) return 3'b001;
    if (oy >= TILE - GAP - 8 && oy < TILE - GAP && ox >= GAP && ox < GAP + 8 * code)
      return 3'b111;
    case ((code - 1) % 5)
      0: return 3'b110;
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [191:0] rand_board();
    logic [191:0] bd;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: bd[12*i +: 12] = 12'd0;
        1: bd[12*i +: 12] = 12'(1 << $urandom_range(1, 11));
        2: bd[12*i +: 12] = 12'($urandom);
        default: bd[12*i +: 12] = 12'(1 << $urandom_range(0, 11));
      endcase
    end
    return bd;
  endfunction

  // One Clk edge with full output comparison. Output after pixel tick k shows
  // pixel k-3; its tile code is taken with the board/Test seen at tick k-1.
  task automatic step();
    logic [191:0] mc_pre;
    logic         t_pre;
    int           k, p, x, y;
    mc_pre = mc;
    t_pre  = test;
    @(posedge clk); #1;
    e_cnt++;
    held_fs = 1'b0;
    if (e_cnt % PIX_DIV == 0) begin
      k = e_cnt / PIX_DIV;
      p = k - 3;
      held_rgb = pend;
      x = (p < 0) ? 0 : p % H_TOTAL;
      y = (p < 0) ? 0 : (p / H_TOTAL) % V_TOTAL;
      held_hs = (p < 0) || !(x >= HS_START && x < HS_END);
      held_vs = (p < 0) || !(y >= VS_START && y < VS_END);
      held_fs = (k % FRAME == 0);
      pend = colour(k - 2, shadow_m, t_pre);
      if (k % FRAME == 0) shadow_m = mc_pre;
      if (p >= FRAME && p < 2 * FRAME) begin
        if (!h_sync) hs_low++;
        if (!v_sync) vs_low++;
      end
    end
    check("rgb", {29'd0, r, g, b}, {29'd0, held_rgb});
    check("h_sync", {31'd0, h_sync}, {31'd0, held_hs});
    check("v_sync", {31'd0, v_sync}, {31'd0, held_vs});
    check("frame_start", {31'd0, fs}, {31'd0, held_fs});
    if (fs && first_fs < 0) first_fs = e_cnt;
  endtask

  task automatic run_to(input int k_target);
    while (e_cnt < k_target * PIX_DIV) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_h_sync"}, {31'd0, h_sync}, 32'd1);
    check({tag, "_v_sync"}, {31'd0, v_sync}, 32'd1);
    check({tag, "_rgb"}, {29'd0, r, g, b}, 32'd0);
    check({tag, "_frame_start"}, {31'd0, fs}, 32'd0);
  endtask

  initial begin
    logic [191:0] board_a;
    rst_n    = 1'b0;
    test     = 1'b0;
    mc       = '0;
    e_cnt    = 0;
    first_fs = -1;
    hs_low   = 0;
    vs_low   = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Run a while, then reset in mid-frame with a busy board and Test on.
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    mc    = rand_board();
    test  = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;

    // Board A with the named corner cases; loaded only at the first snapshot.
    board_a = rand_board();
    board_a[12*0  +: 12] = 12'd2;
    board_a[12*15 +: 12] = 12'd2048;
    board_a[12*5  +: 12] = 12'd3;
    board_a[12*6  +: 12] = 12'hFFF;
    board_a[12*1  +: 12] = 12'd0;
    board_a[12*2  +: 12] = 12'd1;
    test     = 1'b0;
    mc       = board_a;
    shadow_m = '0;
    pend     = 3'b000;
    held_rgb = 3'b000;
    held_hs  = 1'b1;
    held_vs  = 1'b1;
    held_fs  = 1'b0;
    rst_n    = 1'b1;

    // Frame 0 empty, frame 1 shows A despite a mid-frame board change.
    run_to(FRAME + 40 * H_TOTAL);
    mc = rand_board();
    // Frame 2 shows the new board, then the test pattern from line 45.
    run_to(2 * FRAME + 44 * H_TOTAL + 100);
    test = 1'b1;
    mc   = rand_board();
    run_to(3 * FRAME + 4);

    check("first_frame_start_cycle", 32'(first_fs), 32'(PIX_DIV * FRAME));
    check("h_sync_low_pixels_per_frame", 32'(hs_low), 32'(V_TOTAL * (HS_END - HS_START)));
    check("v_sync_low_pixels_per_frame", 32'(vs_low), 32'(H_TOTAL * (VS_END - VS_START)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
